// File: rtl/heap_request_sequencer_if.sv
`default_nettype none
// ============================================================================
// heap_request_sequencer_if : request/response valid-ready bundle
// Revision 1.0 - initial release
// ============================================================================
interface heap_request_sequencer_if #(
  parameter int ADDRESS_BITS = 2,
  parameter int INDEX_BITS   = 1,
  parameter int DATA_BITS    = 12
);
  logic                    reqValid;
  logic                    reqReady;
  logic [7:0]              reqAction;
  logic [ADDRESS_BITS-1:0] reqArray;
  logic [INDEX_BITS-1:0]   reqIndex;
  logic [DATA_BITS-1:0]    reqIn;

  logic                    rspValid;
  logic                    rspReady;
  logic [7:0]              rspAction;
  logic [DATA_BITS-1:0]    rspOut;
  logic [31:0]             rspError;

  modport master (
    output reqValid, reqAction, reqArray, reqIndex, reqIn, rspReady,
    input  reqReady, rspValid, rspAction, rspOut, rspError
  );

  modport slave (
    input  reqValid, reqAction, reqArray, reqIndex, reqIn, rspReady,
    output reqReady, rspValid, rspAction, rspOut, rspError
  );
endinterface
`default_nettype wire

// File: rtl/heap_request_sequencer.sv
`default_nettype none
// ============================================================================
// heap_request_sequencer : FIFO-buffered issue/capture sequencer for the heap
// Revision 1.0 - initial release
// ============================================================================
module heap_request_sequencer #(
  parameter int ADDRESS_BITS = 2,
  parameter int INDEX_BITS   = 1,
  parameter int DATA_BITS    = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  heap_request_sequencer_if.slave bus,
  output logic                    heapClock,
  output logic [7:0]              heapAction,
  output logic [ADDRESS_BITS-1:0] heapArray,
  output logic [INDEX_BITS-1:0]   heapIndex,
  output logic [DATA_BITS-1:0]    heapIn,
  input  logic [DATA_BITS-1:0]    heapOut,
  input  logic [31:0]             heapError,
  output logic                    busy,
  output logic [31:0]             requests,
  output logic [31:0]             errors
);

  localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_BITS = 8 + ADDRESS_BITS + INDEX_BITS + DATA_BITS;
  localparam logic [PTR_BITS:0] FULL_COUNT = FIFO_DEPTH[PTR_BITS:0];
  localparam logic [31:0] UNKNOWN_ACTION = 32'd10000281;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;

  logic [2:0] state;
  logic [2:0] state_next;

  logic [ENTRY_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [PTR_BITS:0]     fifo_count;
  logic                  full;
  logic                  empty;
  logic                  push;

  logic [ENTRY_BITS-1:0] head;
  logic [7:0]            head_action;
  logic                  head_legal;

  logic                  pop;
  logic                  issue;
  logic                  capture;
  logic                  handshake;
  logic                  bypass;

  logic [7:0]            rsp_action;
  logic [DATA_BITS-1:0]  rsp_out;
  logic [31:0]           rsp_error;

  // Full/empty come from registered occupancy only, so a same-cycle pop never frees a slot early.
  assign full  = (fifo_count == FULL_COUNT);
  assign empty = (fifo_count == '0);
  assign push  = bus.reqValid && !full;

  assign head        = fifo_mem[rd_ptr];
  assign head_action = head[ENTRY_BITS-1 -: 8];
  assign head_legal  = (head_action >= 8'd1) && (head_action <= 8'd30);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.reqAction, bus.reqArray, bus.reqIndex, bus.reqIn};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_next = head_legal ? S_ISSUE : S_CAPTURE;
        end
      end
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_RESPOND;
      S_RESPOND: begin
        if (bus.rspReady) begin
          state_next = S_IDLE;
        end
      end
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      S_IDLE:    pop       = !empty;
      S_ISSUE:   issue     = 1'b1;
      S_CAPTURE: capture   = 1'b1;
      S_RESPOND: handshake = bus.rspReady;
      default:   pop       = 1'b0;
    endcase
  end

  // Heap inputs stay parked on the last popped request so the heap never sees them move mid-access.
  always_ff @(posedge clock) begin
    if (reset) begin
      heapClock  <= 1'b0;
      heapAction <= '0;
      heapArray  <= '0;
      heapIndex  <= '0;
      heapIn     <= '0;
      bypass     <= 1'b0;
    end else begin
      if (pop) begin
        heapAction <= head_action;
        heapArray  <= head[DATA_BITS+INDEX_BITS +: ADDRESS_BITS];
        heapIndex  <= head[DATA_BITS +: INDEX_BITS];
        heapIn     <= head[DATA_BITS-1:0];
        bypass     <= !head_legal;
      end
      if (issue) begin
        heapClock <= !heapClock;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_action <= '0;
      rsp_out    <= '0;
      rsp_error  <= '0;
    end else if (capture) begin
      rsp_action <= heapAction;
      rsp_out    <= bypass ? '0 : heapOut;
      rsp_error  <= bypass ? UNKNOWN_ACTION : heapError;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      requests <= '0;
      errors   <= '0;
    end else if (handshake) begin
      requests <= requests + 32'd1;
      if (rsp_error != 32'd0) begin
        errors <= errors + 32'd1;
      end
    end
  end

  assign bus.reqReady  = !full;
  assign bus.rspValid  = (state == S_RESPOND);
  assign bus.rspAction = rsp_action;
  assign bus.rspOut    = rsp_out;
  assign bus.rspError  = rsp_error;

  assign busy = (state != S_IDLE) || !empty;

endmodule
`default_nettype wire

// File: tb/tb_heap_request_sequencer.sv
`default_nettype none
// ============================================================================
// tb_heap_request_sequencer : scoreboard bench with a behavioural heap stand-in
// Revision 1.0 - initial release
// ============================================================================
module tb_heap_request_sequencer;

  typedef struct packed {
    logic [7:0]  action;
    logic [11:0] out;
    logic [31:0] err;
    logic        legal;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        heapClock;
  logic [7:0]  heapAction;
  logic [1:0]  heapArray;
  logic [0:0]  heapIndex;
  logic [11:0] heapIn;
  logic [11:0] heapOut;
  logic [31:0] heapError;
  logic        busy;
  logic [31:0] requests;
  logic [31:0] errors;

  int   tests = 0;
  int   fails = 0;
  int   rsp_mode = 0;
  int   toggles = 0;
  int   legal_seen = 0;
  int   done = 0;
  int   err_done = 0;
  exp_t sb[$];

  heap_request_sequencer_if #(.ADDRESS_BITS(2), .INDEX_BITS(1), .DATA_BITS(12)) bus ();

  heap_request_sequencer #(
    .ADDRESS_BITS(2), .INDEX_BITS(1), .DATA_BITS(12), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .heapClock(heapClock), .heapAction(heapAction), .heapArray(heapArray),
    .heapIndex(heapIndex), .heapIn(heapIn), .heapOut(heapOut), .heapError(heapError),
    .busy(busy), .requests(requests), .errors(errors)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in heap: a pure function of the presented request fields.
  function automatic logic [43:0] heap_model(input logic [7:0] a, input logic [1:0] arr,
                                             input logic [0:0] idx, input logic [11:0] din);
    int unsigned v;
    if (a == 8'd4 && arr == 2'd1) return {32'd0, 12'd5};
    if (a == 8'd9 && arr == 2'd2) return {32'd0, 12'd2};
    if (a == 8'd7) return {32'd10000123, 10'd0, arr};
    v = din + a * 3 + arr * 17 + idx * 101;
    return {32'd0, v[11:0]};
  endfunction

  always_comb {heapError, heapOut} = heap_model(heapAction, heapArray, heapIndex, heapIn);

  function automatic exp_t expect_of(input logic [7:0] a, input logic [1:0] arr,
                                     input logic [0:0] idx, input logic [11:0] din);
    exp_t e;
    logic [43:0] h;
    e.action = a;
    e.legal  = (a >= 8'd1) && (a <= 8'd30);
    if (e.legal) begin
      h     = heap_model(a, arr, idx, din);
      e.out = h[11:0];
      e.err = h[43:12];
    end else begin
      e.out = 12'd0;
      e.err = 32'd10000281;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [1:0] arr, input logic [0:0] idx,
                      input logic [11:0] din, output bit acc);
    @(negedge clock);
    bus.reqValid  = 1'b1;
    bus.reqAction = a;
    bus.reqArray  = arr;
    bus.reqIndex  = idx;
    bus.reqIn     = din;
    acc = bus.reqReady;
    if (acc) sb.push_back(expect_of(a, arr, idx, din));
    @(posedge clock);
  endtask

  task automatic send_wait(input logic [7:0] a, input logic [1:0] arr, input logic [0:0] idx,
                           input logic [11:0] din);
    bit acc;
    int tries = 0;
    do begin
      send(a, arr, idx, din, acc);
      tries++;
    end while (!acc && tries < 400);
    check("req_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.reqValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    forever begin
      @(heapClock);
      if (!reset) toggles++;
    end
  end

  // Response monitor: picks rspReady each cycle and scores every handshake.
  initial begin
    exp_t e;
    bus.rspReady = 1'b0;
    forever begin
      @(negedge clock);
      case (rsp_mode)
        0:       bus.rspReady = 1'b1;
        1:       bus.rspReady = 1'($urandom_range(0, 1));
        default: bus.rspReady = 1'b0;
      endcase
      if (!reset && bus.rspValid && bus.rspReady) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rspAction", {24'd0, bus.rspAction}, {24'd0, e.action});
          check("rspOut", {20'd0, bus.rspOut}, {20'd0, e.out});
          check("rspError", bus.rspError, e.err);
          legal_seen += int'(e.legal);
          check("heapClock_edges", toggles, legal_seen);
          check("requests_count", requests, done);
          check("errors_count", errors, err_done);
          done++;
          if (e.err != 32'd0) err_done++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   acc;
    int   acc_count;
    int   snap;
    int   seen;
    logic hc0;
    int unsigned r;
    logic [7:0] a;

    reset = 1'b1;
    bus.reqValid = 1'b0; bus.reqAction = '0; bus.reqArray = '0; bus.reqIndex = '0; bus.reqIn = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_reqReady", {31'd0, bus.reqReady}, 32'd1);
    check("rst_rspValid", {31'd0, bus.rspValid}, 32'd0);
    check("rst_rspAction", {24'd0, bus.rspAction}, 32'd0);
    check("rst_rspOut", {20'd0, bus.rspOut}, 32'd0);
    check("rst_rspError", bus.rspError, 32'd0);
    check("rst_heapClock", {31'd0, heapClock}, 32'd0);
    check("rst_heapAction", {24'd0, heapAction}, 32'd0);
    check("rst_heapArray", {30'd0, heapArray}, 32'd0);
    check("rst_heapIndex", {31'd0, heapIndex}, 32'd0);
    check("rst_heapIn", {20'd0, heapIn}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_requests", requests, 32'd0);
    check("rst_errors", errors, 32'd0);
    reset = 1'b0;

    // Latency of a legal request
    send(8'd4, 2'd1, 1'b0, 12'd0, acc);
    check("size_accept", {31'd0, acc}, 32'd1);
    @(negedge clock);
    bus.reqValid = 1'b0;
    hc0 = heapClock;
    check("E0_heapAction", {24'd0, heapAction}, 32'd0);
    @(negedge clock);
    check("E1_heapAction", {24'd0, heapAction}, 32'd4);
    check("E1_heapArray", {30'd0, heapArray}, 32'd1);
    check("E1_heapClock", {31'd0, heapClock}, {31'd0, hc0});
    @(negedge clock);
    check("E2_heapClock", {31'd0, heapClock}, {31'd0, !hc0});
    @(negedge clock);
    check("E3_rspValid", {31'd0, bus.rspValid}, 32'd0);
    @(negedge clock);
    check("E4_rspValid", {31'd0, bus.rspValid}, 32'd1);
    drain();
    check("size_requests", requests, 32'd1);
    check("size_errors", errors, 32'd0);

    send_wait(8'd9, 2'd2, 1'b0, 12'h010);
    idle();
    drain();

    // Bypassed requests: response two edges after acceptance, heap never clocked
    snap = err_done;
    hc0  = heapClock;
    send(8'd0, 2'd0, 1'b0, 12'd0, acc);
    idle();
    @(negedge clock);
    check("byp_E1_rspValid", {31'd0, bus.rspValid}, 32'd0);
    @(negedge clock);
    check("byp_E2_rspValid", {31'd0, bus.rspValid}, 32'd1);
    send_wait(8'd31, 2'd3, 1'b1, 12'hABC);
    idle();
    drain();
    check("illegal_errors", errors, snap + 2);
    check("illegal_heapClock", {31'd0, heapClock}, {31'd0, hc0});

    snap = err_done;
    send_wait(8'd7, 2'd1, 1'b0, 12'd3);
    idle();
    drain();
    check("heap_error_count", errors, snap + 1);

    // Backpressure: FIFO plus one in-flight request
    snap = done;
    rsp_mode = 2;
    acc_count = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'd4, 2'(i), 1'(i), 12'(i * 7), acc);
      if (acc) acc_count++;
    end
    idle();
    check("bp_accepted", acc_count, 32'd5);
    check("bp_reqReady", {31'd0, bus.reqReady}, 32'd0);
    check("bp_rspValid", {31'd0, bus.rspValid}, 32'd1);
    rsp_mode = 0;
    drain();
    check("bp_requests", requests, snap + 5);

    // Reset while the first request sits in WAIT with two more queued
    send(8'd5, 2'd0, 1'b0, 12'd1, acc);
    send(8'd6, 2'd1, 1'b1, 12'd2, acc);
    send(8'd8, 2'd2, 1'b0, 12'd3, acc);
    @(negedge clock);
    bus.reqValid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("mr_rspValid", {31'd0, bus.rspValid}, 32'd0);
    check("mr_heapClock", {31'd0, heapClock}, 32'd0);
    check("mr_heapAction", {24'd0, heapAction}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_reqReady", {31'd0, bus.reqReady}, 32'd1);
    sb.delete();
    toggles = 0; legal_seen = 0; done = 0; err_done = 0;
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.rspValid) seen++;
    end
    check("mr_no_response", seen, 32'd0);
    check("mr_requests", requests, 32'd0);

    // Randomised traffic with random response backpressure
    rsp_mode = 1;
    for (int i = 0; i < 80; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        idle();
        repeat (gap) @(posedge clock);
      end
      r = $urandom_range(0, 40);
      a = (r > 35) ? 8'hFF : 8'(r);
      send_wait(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 12'($urandom));
    end
    idle();
    drain();
    check("final_requests", requests, done);
    check("final_errors", errors, err_done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
